menu_event_router: RTL and testbench
====================================

MENU_EVENT_ROUTER -- requirements
Module: menu_event_router

Interface
REQ-001 SHALL have parameter NCH, default 11, meaning number of screen channels (min 2).
REQ-002 SHALL have parameter NEV, default 3, meaning number of button event types (menu, down, up).
REQ-003 SHALL have parameter GUARD, default 4, meaning cycles events are blocked after a channel switch (min 1).
REQ-004 SHALL derive local constant SELW = clog2(NCH).
REQ-005 SHALL have port clk  in  1  single system clock; one clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  reset is synchronous and active-high.
REQ-007 SHALL have port select  in  SELW  requested channel.
REQ-008 SHALL have port ev_in  in  NEV  debounced button levels, bit order menu=0, down=1, up=2.
REQ-009 SHALL have port ch_busy  in  NCH  per-channel "cannot accept event" flag.
REQ-010 SHALL have port ev_out  out  NCH*NEV  one-cycle event pulses; bit ch*NEV+e = event e for channel ch.
REQ-011 SHALL have port active_ch  out  SELW  channel currently routed.
REQ-012 SHALL have port guard_active  out  1  high while in GUARD state.
REQ-013 SHALL have port drop  out  1  one-cycle pulse when an event is lost to overflow.

Function
REQ-014 SHALL register all outputs; no latches; every ev_out bit not explicitly pulsed is 0 in every cycle.
REQ-015 SHALL keep ev_q, the registered copy of ev_in; a rising edge of event e is ev_in[e]=1 with ev_q[e]=0 at a clock edge.
REQ-016 SHALL clamp select values >= NCH to channel 0.
REQ-017 SHALL implement FSM with states RUN and GUARD.
REQ-018 In RUN, an edge with ch_busy[active_ch]=0 and no pending event SHALL pulse ev_out[active_ch*NEV+e] in the next cycle, giving latency 1 clock from the sampling edge.
REQ-019 In RUN, an edge with ch_busy[active_ch]=1 SHALL set pending[e], a 1-deep slot per event.
REQ-020 Pending[e] SHALL emit at the first clock edge with ch_busy[active_ch]=0, then clear.
REQ-021 An edge while pending[e] is set and busy SHALL pulse drop and leave pending[e] set, without queuing a second event.
REQ-022 An edge in the same cycle pending[e] is released SHALL be merged into one ev_out pulse and SHALL pulse drop.
REQ-023 Different event types in the same cycle SHALL pulse independently; multi-hot within one channel is allowed.
REQ-024 Any clock edge with clamped select != active_ch SHALL update active_ch, enter GUARD, load counter with GUARD-1, and clear all pending without asserting drop.
REQ-025 In GUARD, edges SHALL be discarded, with no ev_out and no drop, while ev_q keeps tracking.
REQ-026 In GUARD, a further select change SHALL reload the counter; at counter 0 the FSM SHALL move to RUN.
REQ-027 ev_out SHALL never address a channel other than active_ch.

Reset
REQ-028 Reset SHALL be synchronous: at a clock edge with reset=1, ev_out=0, drop=0, pending=0, active_ch=0, state=RUN, guard_active=0, counter=0.
REQ-029 Reset SHALL set ev_q to all ones, so buttons held through reset produce no event.
REQ-030 Reset asserted mid-GUARD or with events pending SHALL discard everything, with no drop pulse.

Structure
REQ-031 SHALL use a shared package menu_router_pkg holding event index constants EV_MENU=0, EV_DOWN=1, EV_UP=2, the default NEV, and the state enum (RUN, GUARD).
REQ-032 SHALL use one sub-module, evt_edge_pend, for per-event edge detect plus pending slot and drop logic, instantiated NEV times.
REQ-033 The top SHALL hold the FSM, guard counter, select clamp and the one-hot output decode.

Verification
REQ-034 Scenario: NCH=11, select=3, ev_in[2] 0->1, busy low -> exactly ev_out[11] high for 1 cycle, 1 clock after the edge; all other bits 0.
REQ-035 Scenario: ch_busy[3]=1, ev_in[0] edge -> no output; busy drops 5 cycles later -> ev_out[9] pulses once, at the first edge after the drop.
REQ-036 Scenario: busy held, two ev_in[1] edges -> one drop pulse; release busy -> a single ev_out[10] pulse.
REQ-037 Scenario: select 3->7, then ev_in[2] edge 2 cycles later -> guard_active high 4 cycles, no ev_out, no drop; an edge after guard -> ev_out[23].
REQ-038 Scenario: select=13 (out of range) -> active_ch=0; ev_in[0] edge -> ev_out[0].
REQ-039 Scenario: ev_in=3'b111 held through reset release -> no ev_out; reset asserted with pending set -> pending cleared, drop stays 0.

Source files
------------

// File: rtl/menu_router_pkg.sv
// Shared definitions for the menu event router: event indices, default event
// count and the router state type.
package menu_router_pkg;

  localparam int EV_MENU     = 0;
  localparam int EV_DOWN     = 1;
  localparam int EV_UP       = 2;
  localparam int NEV_DEFAULT = 3;

  typedef enum logic {
    RUN   = 1'b0,
    GUARD = 1'b1
  } state_e;

endpackage

// File: rtl/evt_edge_pend.sv
// One button event: rising-edge detect against the registered level, a 1-deep
// pending slot held while the target channel is busy, and overflow detection.
module evt_edge_pend (
  input  logic clk,
  input  logic reset,
  input  logic ev_in,
  input  logic busy,
  input  logic accept,
  input  logic flush,
  output logic fire,
  output logic drop
);

  logic ev_q_q, ev_q_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    rise   = ev_in & ~ev_q_q;
    ev_q_d = ev_in;
    pend_d = pend_q;
    fire   = 1'b0;
    drop   = 1'b0;
    if (flush) begin
      pend_d = 1'b0;
    end else if (accept) begin
      // A new edge on top of a held event is lost, whether or not the slot drains now.
      drop = rise & pend_q;
      if (busy) begin
        pend_d = pend_q | rise;
      end else begin
        fire   = rise | pend_q;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_q_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      ev_q_q <= ev_q_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/menu_event_router.sv
// Routes debounced button edges to the selected screen channel as one-cycle
// pulses, with a post-switch guard window and per-event busy buffering.
module menu_event_router
  import menu_router_pkg::state_e;
  import menu_router_pkg::RUN;
  import menu_router_pkg::NEV_DEFAULT;
#(
  parameter  int NCH   = 11,
  parameter  int NEV   = NEV_DEFAULT,
  parameter  int GUARD = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      select,
  input  logic [NEV-1:0]       ev_in,
  input  logic [NCH-1:0]       ch_busy,
  output logic [NCH*NEV-1:0]   ev_out,
  output logic [SELW-1:0]      active_ch,
  output logic                 guard_active,
  output logic                 drop
);

  localparam int unsigned OUTW = NCH * NEV;
  localparam int unsigned CW   = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SELW-1:0]   active_ch_q, active_ch_d;
  logic              guard_active_q, guard_active_d;
  logic [OUTW-1:0]   ev_out_q, ev_out_d;
  logic              drop_q, drop_d;

  logic [SELW-1:0]   sel_clamped;
  logic              sel_switch;
  logic              accept;
  logic              busy;
  logic [NEV-1:0]    fire;
  logic [NEV-1:0]    ev_drop;

  for (genvar g = 0; g < NEV; g++) begin : g_ev
    evt_edge_pend u_pend (
      .clk    (clk),
      .reset  (reset),
      .ev_in  (ev_in[g]),
      .busy   (busy),
      .accept (accept),
      .flush  (sel_switch),
      .fire   (fire[g]),
      .drop   (ev_drop[g])
    );
  end

  always_comb begin
    sel_clamped = (32'(select) >= NCH) ? '0 : select;
    sel_switch  = (sel_clamped != active_ch_q);
    accept      = (state_q == RUN) && !sel_switch;
    busy        = ch_busy[active_ch_q];

    state_d     = state_q;
    cnt_d       = cnt_q;
    active_ch_d = active_ch_q;
    if (sel_switch) begin
      active_ch_d = sel_clamped;
      state_d     = menu_router_pkg::GUARD;
      cnt_d       = CW'(GUARD - 1);
    end else if (state_q == menu_router_pkg::GUARD) begin
      if (cnt_q == '0) state_d = RUN;
      else             cnt_d   = cnt_q - CW'(1);
    end
    guard_active_d = (state_d == menu_router_pkg::GUARD);

    // fire is already gated by accept, so the decode only needs the channel offset.
    ev_out_d = OUTW'(fire) << (NEV * int'(active_ch_q));
    drop_d   = |ev_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      active_ch_q    <= '0;
      guard_active_q <= 1'b0;
      ev_out_q       <= '0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_ch_q    <= active_ch_d;
      guard_active_q <= guard_active_d;
      ev_out_q       <= ev_out_d;
      drop_q         <= drop_d;
    end
  end

  assign ev_out       = ev_out_q;
  assign active_ch    = active_ch_q;
  assign guard_active = guard_active_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_menu_event_router.sv
// Self-checking bench for menu_event_router: fixed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_menu_event_router;
  import menu_router_pkg::EV_MENU;
  import menu_router_pkg::EV_DOWN;
  import menu_router_pkg::EV_UP;

  localparam int NCH       = 11;
  localparam int NEV       = 3;
  localparam int GUARD_CYC = 4;
  localparam int SELW      = $clog2(NCH);
  localparam int OUTW      = NCH * NEV;

  logic              clk = 1'b0;
  logic              reset;
  logic [SELW-1:0]   select;
  logic [NEV-1:0]    ev_in;
  logic [NCH-1:0]    ch_busy;
  logic [OUTW-1:0]   ev_out;
  logic [SELW-1:0]   active_ch;
  logic              guard_active;
  logic              drop;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  menu_event_router #(.NCH(NCH), .NEV(NEV), .GUARD(GUARD_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .select       (select),
    .ev_in        (ev_in),
    .ch_busy      (ch_busy),
    .ev_out       (ev_out),
    .active_ch    (active_ch),
    .guard_active (guard_active),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  // Behavioural model: guard window as a count of remaining blocked cycles.
  int              m_ch;
  int              m_left;
  bit [NEV-1:0]    m_pend;
  bit [NEV-1:0]    m_prev;
  bit [OUTW-1:0]   exp_out;
  bit              exp_drop;

  always @(posedge clk) begin
    bit [NEV-1:0] rises;
    int tgt;
    if (reset) begin
      m_ch = 0; m_left = 0; m_pend = '0; m_prev = '1;
      exp_out = '0; exp_drop = 1'b0;
    end else begin
      rises  = ev_in & ~m_prev;
      m_prev = ev_in;
      tgt    = (int'(select) < NCH) ? int'(select) : 0;
      exp_out  = '0;
      exp_drop = 1'b0;
      if (tgt != m_ch) begin
        m_ch = tgt; m_left = GUARD_CYC; m_pend = '0;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end else begin
        for (int e = 0; e < NEV; e++) begin
          if (rises[e] && m_pend[e]) exp_drop = 1'b1;
          if (ch_busy[m_ch]) begin
            if (rises[e]) m_pend[e] = 1'b1;
          end else begin
            if (rises[e] || m_pend[e]) exp_out[m_ch*NEV+e] = 1'b1;
            m_pend[e] = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model.ev_out", 64'(ev_out), 64'(exp_out));
      check("model.drop", 64'(drop), 64'(exp_drop));
      check("model.active_ch", 64'(active_ch), 64'(m_ch));
      check("model.guard_active", 64'(guard_active), 64'(m_left > 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int gcount;
    reset = 1'b1; select = '0; ev_in = '0; ch_busy = '0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst.ev_out", 64'(ev_out), 64'd0);
    check("rst.active_ch", 64'(active_ch), 64'd0);
    check("rst.guard", 64'(guard_active), 64'd0);
    check("rst.drop", 64'(drop), 64'd0);
    reset = 1'b0;

    // Single edge to channel 3, up event
    select = 4'd3; tick();
    for (int i = 0; i < 6; i++) tick();
    ev_in[EV_UP] = 1'b1; tick();
    check("s34.pulse", 64'(ev_out), 64'h800);
    tick();
    check("s34.gone", 64'(ev_out), 64'd0);

    // Busy channel holds a menu event until busy drops
    ev_in = '0; tick();
    ch_busy[3] = 1'b1;
    ev_in[EV_MENU] = 1'b1; tick();
    check("s35.held", 64'(ev_out), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    ch_busy[3] = 1'b0; tick();
    check("s35.release", 64'(ev_out), 64'h200);
    tick();
    check("s35.once", 64'(ev_out), 64'd0);

    // Overflow: second down edge while pending and busy
    ev_in = '0; ch_busy[3] = 1'b1; tick();
    ev_in[EV_DOWN] = 1'b1; tick();
    ev_in = '0; tick();
    ev_in[EV_DOWN] = 1'b1; tick();
    check("s36.drop", 64'(drop), 64'd1);
    tick();
    check("s36.drop_once", 64'(drop), 64'd0);
    ch_busy[3] = 1'b0; tick();
    check("s36.single", 64'(ev_out), 64'h400);
    tick();
    check("s36.after", 64'(ev_out), 64'd0);

    // Switch to channel 7; edge during guard is discarded
    ev_in = '0; tick();
    select = 4'd7; tick();
    check("s37.active", 64'(active_ch), 64'd7);
    gcount = guard_active ? 1 : 0;
    tick();
    if (guard_active) gcount++;
    ev_in[EV_UP] = 1'b1; tick();
    check("s37.blocked", 64'(ev_out), 64'd0);
    check("s37.nodrop", 64'(drop), 64'd0);
    if (guard_active) gcount++;
    for (int i = 0; i < 10 && guard_active; i++) begin
      tick();
      if (guard_active) gcount++;
    end
    check("s37.guard_len", 64'(gcount), 64'd4);
    ev_in = '0; tick();
    ev_in[EV_UP] = 1'b1; tick();
    check("s37.after", 64'(ev_out), 64'h80_0000);

    // Out-of-range select clamps to channel 0
    ev_in = '0; select = 4'd13; tick();
    check("s38.clamp", 64'(active_ch), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    ev_in[EV_MENU] = 1'b1; tick();
    check("s38.pulse", 64'(ev_out), 64'h1);

    // Buttons held through reset; reset with an event pending
    ev_in = 3'b111; reset = 1'b1; tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s39.held", 64'(ev_out), 64'd0);
    end
    ev_in = '0; tick();
    ch_busy[0] = 1'b1; ev_in[EV_MENU] = 1'b1; tick();
    reset = 1'b1; tick();
    check("s39.rst_drop", 64'(drop), 64'd0);
    reset = 1'b0; ch_busy = '0; tick();
    check("s39.cleared", 64'(ev_out), 64'd0);
    check("s39.cleared_drop", 64'(drop), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) select = SELW'($urandom_range(0, 15));
      for (int e = 0; e < NEV; e++)
        if ($urandom_range(0, 2) == 0) ev_in[e] = ~ev_in[e];
      if ($urandom_range(0, 3) == 0) ch_busy = NCH'($urandom());
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
